// File: rtl/mul_seq.sv
// mul_seq: 8x8 unsigned shift-and-add multiplier. It sequences the shared
// combinational 8-bit ALU through ADD / ROTH / ROTL for eight iterations
// and returns a 16-bit product. While busy it owns the ALU operand ports.
module mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  mul_a,
  input  logic [7:0]  mul_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        zero,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_s_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_c
);

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_RRC  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_ROTH = 3'd2,
    S_ROTL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  mcand;
  logic [7:0]  p_hi;
  logic [7:0]  p_lo;
  logic        c_reg;
  logic [2:0]  cnt;

  // Carry register is the only status the ALU ever sees; V/N/Z stay clear.
  assign alu_s_in = {3'b000, c_reg};

  // Sequencer: accepts a start, walks 8 x (ADD, ROTH, ROTL), then DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
      zero    <= 1'b1;
      mcand   <= 8'h00;
      p_hi    <= 8'h00;
      p_lo    <= 8'h00;
      c_reg   <= 1'b0;
      cnt     <= 3'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= mul_a;
            p_lo  <= mul_b;
            p_hi  <= 8'h00;
            c_reg <= 1'b0;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= S_ADD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          // 9-bit partial sum lands in {c_reg, p_hi}
          p_hi  <= alu_result;
          c_reg <= alu_c;
          state <= S_ROTH;
        end
        S_ROTH: begin
          // carry of the sum enters p_hi[7]; p_hi[0] falls into carry
          p_hi  <= alu_result;
          c_reg <= alu_c;
          state <= S_ROTL;
        end
        S_ROTL: begin
          // p_hi[0] enters p_lo[7]; consumed multiplier bit drops into carry
          p_lo  <= alu_result;
          c_reg <= alu_c;
          if (cnt == 3'd7) begin
            product <= {p_hi, alu_result};
            zero    <= ({p_hi, alu_result} == 16'h0000);
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= S_ADD;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU operand/opcode decode straight from state and registers.
  always_comb begin
    alu_op = OP_PASS;
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    case (state)
      S_ADD: begin
        alu_op = OP_ADD;
        alu_a  = p_hi;
        alu_b  = p_lo[0] ? mcand : 8'h00;
      end
      S_ROTH: begin
        alu_op = OP_RRC;
        alu_a  = p_hi;
      end
      S_ROTL: begin
        alu_op = OP_RRC;
        alu_a  = p_lo;
      end
      default: begin
        alu_op = OP_PASS;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// Testbench for mul_seq: behavioural ALU beside the DUT, table of directed
// multiplications, hand-written back-to-back and mid-sequence reset cases,
// and a batch of random pairs against a*b.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        zero;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_s_in;
  logic [7:0]  alu_result;
  logic        alu_c;

  int total;
  int bad;

  mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .zero       (zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_s_in   (alu_s_in),
    .alu_result (alu_result),
    .alu_c      (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model for the three opcodes the sequencer uses.
  always_comb begin
    alu_result = 8'h00;
    alu_c      = 1'b0;
    case (alu_op)
      4'b1000: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0100: begin
        alu_result = {alu_s_in[0], alu_a[7:1]};
        alu_c      = alu_a[0];
      end
      4'b0110: alu_result = alu_a;
      default: begin
        alu_result = 8'h00;
        alu_c      = 1'b0;
      end
    endcase
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one product and stop in its DONE cycle (or after a bounded wait).
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output logic z,
                         output int busy_n, output int done_cyc,
                         output int op_err, output int sin_err);
    logic [3:0] exp_op;
    prod     = 16'hxxxx;
    z        = 1'bx;
    busy_n   = 0;
    done_cyc = 0;
    op_err   = 0;
    sin_err  = 0;
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (alu_s_in[3:1] != 3'b000) sin_err++;
      if (done) begin
        done_cyc = c;
        prod     = product;
        z        = zero;
      end else begin
        if (busy) busy_n++;
        if (c <= 24) begin
          exp_op = (((c - 1) % 3) == 0) ? 4'b1000 : 4'b0100;
          if (alu_op != exp_op) op_err++;
        end
        step();
      end
    end
  endtask

  initial begin
    logic [15:0] p;
    logic        z;
    int          bn, dc, oe, se;
    int          cyc, first_done, second_done, seen_done;
    logic [7:0]  ra, rb;
    logic [15:0] rexp;

    total = 0;
    bad   = 0;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   1'b0};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01,  1'b0};
    vecs[2] = '{8'h5A,  8'h00,  16'h0000,  1'b1};
    vecs[3] = '{8'h00,  8'hFF,  16'h0000,  1'b1};
    vecs[4] = '{8'h01,  8'h01,  16'h0001,  1'b0};
    vecs[5] = '{8'h80,  8'h02,  16'h0100,  1'b0};
    vecs[6] = '{8'hFF,  8'h01,  16'h00FF,  1'b0};
    vecs[7] = '{8'h0F,  8'hF0,  16'h0E10,  1'b0};

    // reset with start held: reset must win
    reset = 1'b1;
    start = 1'b1;
    mul_a = 8'h12;
    mul_b = 8'h34;
    step();
    step();
    start = 1'b0;
    reset = 1'b0;
    check("rst_busy",    busy,     0);
    check("rst_done",    done,     0);
    check("rst_product", product,  0);
    check("rst_zero",    zero,     1);
    check("rst_alu_op",  alu_op,   4'b0110);
    check("rst_alu_a",   alu_a,    0);
    check("rst_alu_b",   alu_b,    0);
    check("rst_alu_sin", alu_s_in, 0);
    step();
    check("idle_busy", busy, 0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_mul(vecs[i].a, vecs[i].b, p, z, bn, dc, oe, se);
      check($sformatf("vec%0d_product", i), p, vecs[i].prod);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_busy_cycles", i), bn, 24);
      check($sformatf("vec%0d_done_cycle", i), dc, 25);
      check($sformatf("vec%0d_busy_in_done", i), busy, 0);
      check($sformatf("vec%0d_op_seq_errs", i), oe, 0);
      check($sformatf("vec%0d_sin_errs", i), se, 0);
      step();
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_product_hold", i), product, vecs[i].prod);
    end

    // back-to-back with start held and operands changed mid-sequence
    mul_a = 8'd7;
    mul_b = 8'd9;
    start = 1'b1;
    step();
    first_done  = 0;
    second_done = 0;
    for (int c = 1; c <= 60 && second_done == 0; c++) begin
      if (c == 5) begin
        mul_a = 8'd3;
        mul_b = 8'd3;
      end
      if (c == 30) start = 1'b0;
      if (done) begin
        if (first_done == 0) begin
          first_done = c;
          check("b2b_first_product", product, 16'd63);
        end else begin
          second_done = c;
          check("b2b_second_product", product, 16'd9);
        end
      end
      if (c == 26) check("b2b_busy_c26", busy, 1);
      step();
    end
    check("b2b_first_done_cycle", first_done, 25);
    check("b2b_second_done_cycle", second_done, 50);
    step();
    check("b2b_idle_after", busy, 0);

    // reset during ROTH of iteration 4 (cycle 11)
    mul_a = 8'hAB;
    mul_b = 8'hCD;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 11; c++) step();
    check("midrst_in_roth_op", alu_op, 4'b0100);
    check("midrst_in_roth_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_product", product, 0);
    check("midrst_zero", zero, 1);
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) seen_done++;
      step();
    end
    check("midrst_no_done", seen_done, 0);

    // random pairs against a*b
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rexp = 16'(ra) * 16'(rb);
      run_mul(ra, rb, p, z, bn, dc, oe, se);
      check($sformatf("rnd%0d_product_%0d_x_%0d", i, ra, rb), p, rexp);
      check($sformatf("rnd%0d_zero", i), z, (rexp == 16'h0000));
      check($sformatf("rnd%0d_op_seq_errs", i), oe, 0);
      check($sformatf("rnd%0d_sin_errs", i), se, 0);
      cyc = dc;
      check($sformatf("rnd%0d_done_cycle", i), cyc, 25);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle 8x8 unsigned multiplier sequencer for the DAPA2014 datapath. It has no adder or shifter of its own. It drives the existing combinational 8-bit ALU through a fixed shift-and-add program: add, rotate-right-through-carry high byte, rotate-right-through-carry low byte. It holds the partial product, carry and iteration count in registers and returns a 16-bit product with a one-cycle `done` pulse. It sits beside the ALU and owns the ALU input ports while `busy` is high.

## Interface
- No parameters (width fixed at 8x8 -> 16).
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request; sampled only in IDLE or DONE.
- `mul_a` in 8 — multiplicand, unsigned.
- `mul_b` in 8 — multiplier, unsigned.
- `busy` out 1 — sequence in progress.
- `done` out 1 — one-cycle pulse; `product` valid.
- `product` out 16 — result, held until the next accepted start.
- `zero` out 1 — `product == 0`, updated with `product`.
- `alu_a` out 8 — ALU operand a.
- `alu_b` out 8 — ALU operand b.
- `alu_op` out 4 — ALU opcode.
- `alu_s_in` out 4 — ALU status in {V,N,Z,C}; always `{3'b000, c_reg}`.
- `alu_result` in 8 — ALU result.
- `alu_c` in 1 — ALU carry out; ALU V/N/Z are unused.

## Operation
- ALU opcodes used:
  - 1000 — add; C = bit 8 of the sum, no carry-in.
  - 0100 — rotate right through carry: result `{s_in[0], a[7:1]}`, C = `a[0]`.
  - 0110 — pass a. Idle default: `alu_a`=0, `alu_b`=0.
- Registers: `mcand[7:0]`, `p_hi[7:0]`, `p_lo[7:0]`, `c_reg`, `cnt[2:0]`, state.
- FSM states: IDLE, ADD, ROTH, ROTL, DONE.
- IDLE/DONE with `start`=1:
  - `mcand`<=`mul_a`, `p_lo`<=`mul_b`, `p_hi`<=0, `c_reg`<=0, `cnt`<=0.
  - Next state ADD.
- ADD:
  - `alu_op`=1000, `alu_a`=`p_hi`, `alu_b`=`p_lo[0]` ? `mcand` : 8'h00.
  - `p_hi`<=`alu_result`, `c_reg`<=`alu_c`.
  - Next state ROTH.
- ROTH:
  - `alu_op`=0100, `alu_a`=`p_hi`, `alu_s_in[0]`=`c_reg`.
  - `p_hi`<=`alu_result`, `c_reg`<=`alu_c`.
  - Next state ROTL.
- ROTL:
  - `alu_op`=0100, `alu_a`=`p_lo`, `alu_s_in[0]`=`c_reg`.
  - `p_lo`<=`alu_result`, `c_reg`<=`alu_c` (the discarded multiplier bit).
  - If `cnt`==7: next state DONE. Else `cnt`<=`cnt`+1, next state ADD.
- DONE:
  - `done`=1.
  - On entry: `product`<={`p_hi`,`p_lo`} and `zero` are registered on the ROTL->DONE edge, so both are valid in the DONE cycle.
  - Next state IDLE, or ADD if `start`=1.
- `busy`=1 exactly in ADD, ROTH, ROTL.
- Arithmetic: 9-bit sum {`alu_c`, `alu_result`} is never lost because ROTH shifts the carry into `p_hi[7]`. Product is exact for all 65536 input pairs.
- `start` while `busy`=1 is ignored; `mul_a`/`mul_b` changes while busy have no effect.
- Reset (any state, including mid-sequence):
  - State IDLE, `busy`=0, `done`=0, `product`=0, `zero`=1.
  - `p_hi`=`p_lo`=`mcand`=0, `c_reg`=0, `cnt`=0.
  - `alu_op`=0110, `alu_a`=`alu_b`=0, `alu_s_in`=0.
  - `reset` has priority over `start`.

## Timing
- ALU is combinational: every ALU op completes within the cycle that drives it.
- Fixed latency, data-independent.
- `start` sampled at edge E0:
  - `busy`=1 for cycles 1..24 (8 iterations x 3 states).
  - `done`=1 in cycle 25 only.
  - `product`/`zero` change at the start of cycle 25.
- Back-to-back: `start` in the DONE cycle puts ADD in cycle 26. Throughput is one product per 25 cycles.
- All ALU-side outputs are decoded combinationally from state and registers, with no extra pipeline stage.

## Test plan
- Reset, then `start`, `mul_a`=8'd13, `mul_b`=8'd11:
  - `busy` high for exactly 24 cycles.
  - `done` pulse in cycle 25.
  - `product`=16'd143, `zero`=0.
- `mul_a`=8'hFF, `mul_b`=8'hFF -> `product`=16'hFE01. Checks carry propagation on every ADD.
- Zero operands:
  - `mul_a`=8'h5A, `mul_b`=0 -> `product`=0, `zero`=1.
  - `mul_a`=0, `mul_b`=8'hFF -> `product`=0, `zero`=1.
- `start` held continuously, operands changed mid-sequence:
  - First result uses only the operands latched at the accepted edge.
  - Second sequence begins in the DONE cycle; second `done` comes exactly 25 cycles after the first.
- `reset` asserted during ROTH of iteration 4:
  - Next cycle: `busy`=0, `done`=0, `product`=0, `zero`=1.
  - No `done` follows.
- Random 1000 pairs against a reference `a*b` model:
  - Check `alu_s_in[3:1]`=0 always.
  - Check `alu_op` sequence 1000, 0100, 0100 repeats eight times per product.
